// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instruction_fetch_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;

    typedef enum logic [1:0] {
        StFetch,
        StStall,
        StDrain
    } if_state_e;

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry holding buffer for a fetched word that the decode stage could not yet take.
module if_skid_buffer
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               clr_i,
    input  logic [INSTR_W-1:0] data_i,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic               full_o,
    output logic [INSTR_W-1:0] data_o,
    output logic [ADDR_W-1:0]  pc_o
);

    logic               full_q;
    logic [INSTR_W-1:0] data_q;
    logic [ADDR_W-1:0]  pc_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            data_q <= '0;
            pc_q   <= '0;
        end else if (clr_i) begin
            full_q <= 1'b0;
        end else if (push_i) begin
            full_q <= 1'b1;
            data_q <= data_i;
            pc_q   <= pc_i;
        end else if (pop_i) begin
            full_q <= 1'b0;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;
    assign pc_o   = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC sequencing, memory request handshake, skid buffering and
// redirect handling feeding a registered IF/ID slot.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    input  logic               redirect_valid_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    output logic               id_valid_o,
    input  logic               id_ready_i,
    output logic [INSTR_W-1:0] id_instr_o,
    output logic [5:0]         id_opcode_o,
    output logic [ADDR_W-1:0]  id_pc_o,
    output logic [ADDR_W-1:0]  id_pc_plus4_o
);

    if_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  drain_addr_q, drain_addr_d;
    logic               req_q, req_d;
    logic               id_valid_q, id_valid_d;
    logic [INSTR_W-1:0] id_instr_q, id_instr_d;
    logic [ADDR_W-1:0]  id_pc_q, id_pc_d;
    logic [ADDR_W-1:0]  id_pc_plus4_q, id_pc_plus4_d;

    logic               skid_push, skid_pop, skid_clr, skid_full;
    logic [INSTR_W-1:0] skid_data;
    logic [ADDR_W-1:0]  skid_pc;

    logic               ack_v, slot_free;
    logic [ADDR_W-1:0]  pc_plus4;

    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc_i[1:0];

    if_skid_buffer #(
        .ADDR_W (ADDR_W)
    ) u_skid (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (skid_push),
        .pop_i  (skid_pop),
        .clr_i  (skid_clr),
        .data_i (imem_rdata_i),
        .pc_i   (pc_q),
        .full_o (skid_full),
        .data_o (skid_data),
        .pc_o   (skid_pc)
    );

    // req_q is low in the reset cycle even though the state is already StFetch.
    assign ack_v     = imem_ack_i & req_q & (state_q != StStall);
    assign slot_free = ~id_valid_q | id_ready_i;
    assign pc_plus4  = pc_q + ADDR_W'(4);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drain_addr_d  = drain_addr_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        skid_push     = 1'b0;
        skid_pop      = 1'b0;
        skid_clr      = 1'b0;

        if (id_valid_q && id_ready_i) begin
            id_valid_d = 1'b0;
        end

        if (redirect_valid_i) begin
            id_valid_d = 1'b0;
            skid_clr   = 1'b1;
            pc_d       = {redirect_pc_i[ADDR_W-1:2], 2'b00};
            unique case (state_q)
                StFetch: begin
                    if (!ack_v) begin
                        state_d      = StDrain;
                        drain_addr_d = pc_q;
                    end
                end
                StDrain: begin
                    if (ack_v) begin
                        state_d = StFetch;
                    end
                end
                default: state_d = StFetch;
            endcase
        end else begin
            unique case (state_q)
                StFetch: begin
                    // The skid is only ever full in StStall, so it never competes here.
                    if (ack_v) begin
                        pc_d = pc_plus4;
                        if (slot_free && !skid_full) begin
                            id_valid_d    = 1'b1;
                            id_instr_d    = imem_rdata_i;
                            id_pc_d       = pc_q;
                            id_pc_plus4_d = pc_plus4;
                        end else begin
                            skid_push = 1'b1;
                            state_d   = StStall;
                        end
                    end
                end
                StStall: begin
                    if (slot_free) begin
                        id_valid_d    = 1'b1;
                        id_instr_d    = skid_data;
                        id_pc_d       = skid_pc;
                        id_pc_plus4_d = skid_pc + ADDR_W'(4);
                        skid_pop      = 1'b1;
                        state_d       = StFetch;
                    end
                end
                StDrain: begin
                    if (ack_v) begin
                        state_d = StFetch;
                    end
                end
                default: state_d = StFetch;
            endcase
        end

        req_d = (state_d != StStall);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StFetch;
            pc_q          <= RESET_PC;
            drain_addr_q  <= '0;
            req_q         <= 1'b0;
            id_valid_q    <= 1'b0;
            id_instr_q    <= '0;
            id_pc_q       <= '0;
            id_pc_plus4_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drain_addr_q  <= drain_addr_d;
            req_q         <= req_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = (state_q == StDrain) ? drain_addr_q : pc_q;
    assign id_valid_o    = id_valid_q;
    assign id_instr_o    = id_instr_q;
    assign id_opcode_o   = id_instr_q[OPCODE_MSB:OPCODE_LSB];
    assign id_pc_o       = id_pc_q;
    assign id_pc_plus4_o = id_pc_plus4_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequential fetch, stall/skid, redirects, reset, PC wrap.
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;

    logic        req, ack, redir_v, ready, valid;
    logic [31:0] addr, rdata, redir_pc, instr, pc, pc4;
    logic [5:0]  opcode;

    logic        req2, ack2, valid2;
    logic [31:0] addr2, rdata2, instr2, pc2, pc4_2;
    logic [5:0]  opcode2;

    int n_checks;
    int n_fail;

    instruction_fetch #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .imem_req_o       (req),
        .imem_addr_o      (addr),
        .imem_ack_i       (ack),
        .imem_rdata_i     (rdata),
        .redirect_valid_i (redir_v),
        .redirect_pc_i    (redir_pc),
        .id_valid_o       (valid),
        .id_ready_i       (ready),
        .id_instr_o       (instr),
        .id_opcode_o      (opcode),
        .id_pc_o          (pc),
        .id_pc_plus4_o    (pc4)
    );

    instruction_fetch #(
        .ADDR_W   (32),
        .RESET_PC (32'hFFFF_FFFC)
    ) dut_wrap (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .imem_req_o       (req2),
        .imem_addr_o      (addr2),
        .imem_ack_i       (ack2),
        .imem_rdata_i     (rdata2),
        .redirect_valid_i (1'b0),
        .redirect_pc_i    (32'h0),
        .id_valid_o       (valid2),
        .id_ready_i       (1'b1),
        .id_instr_o       (instr2),
        .id_opcode_o      (opcode2),
        .id_pc_o          (pc2),
        .id_pc_plus4_o    (pc4_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents as a function of address; opcode field is ~addr[7:2].
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[7:2], 2'b01, a[23:0]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] w;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        ack      = 1'b0;
        rdata    = '0;
        redir_v  = 1'b0;
        redir_pc = '0;
        ready    = 1'b0;
        ack2     = 1'b0;
        rdata2   = '0;

        #2;
        check_eq("rst_req", 32'(req), 32'd0);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_pc4", pc4, 32'h0);

        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("req_before_edge", 32'(req), 32'd0);
        tick();
        check_eq("first_req", 32'(req), 32'd1);
        check_eq("first_addr", addr, 32'h0);

        // Back-to-back fetches with decode always ready.
        ready = 1'b1;
        ack   = 1'b1;
        rdata = mem_word(32'h0);
        tick();
        w = mem_word(32'h0);
        check_eq("seq0_valid", 32'(valid), 32'd1);
        check_eq("seq0_pc", pc, 32'h0);
        check_eq("seq0_pc4", pc4, 32'h4);
        check_eq("seq0_instr", instr, w);
        check_eq("seq0_opcode", 32'(opcode), 32'(w[31:26]));
        check_eq("seq0_addr", addr, 32'h4);

        rdata = mem_word(32'h4);
        tick();
        check_eq("seq1_pc", pc, 32'h4);
        check_eq("seq1_addr", addr, 32'h8);

        // Decode stalls while word at 8 returns: it must land in the skid.
        ready = 1'b0;
        rdata = mem_word(32'h8);
        tick();
        check_eq("stall_req", 32'(req), 32'd0);
        check_eq("stall_pc", pc, 32'h4);
        check_eq("stall_valid", 32'(valid), 32'd1);

        // Stray ack while stalled must be ignored.
        rdata = 32'hDEAD_BEEF;
        tick();
        check_eq("stall2_req", 32'(req), 32'd0);
        check_eq("stall2_pc", pc, 32'h4);
        ack = 1'b0;
        tick();
        check_eq("stall3_req", 32'(req), 32'd0);

        ready = 1'b1;
        tick();
        check_eq("unstall_pc", pc, 32'h8);
        check_eq("unstall_instr", instr, mem_word(32'h8));
        check_eq("unstall_valid", 32'(valid), 32'd1);
        check_eq("unstall_req", 32'(req), 32'd1);
        check_eq("unstall_addr", addr, 32'hC);

        ack   = 1'b1;
        rdata = mem_word(32'hC);
        tick();
        check_eq("seq3_pc", pc, 32'hC);
        check_eq("seq3_addr", addr, 32'h10);

        // Redirect with request outstanding at 16: drain it.
        ack      = 1'b0;
        redir_v  = 1'b1;
        redir_pc = 32'h0000_0103;
        tick();
        redir_v = 1'b0;
        check_eq("drain_valid", 32'(valid), 32'd0);
        check_eq("drain_req", 32'(req), 32'd1);
        check_eq("drain_addr", addr, 32'h10);
        tick();
        check_eq("drain_hold_addr", addr, 32'h10);
        ack   = 1'b1;
        rdata = mem_word(32'h10);
        tick();
        check_eq("drain_done_valid", 32'(valid), 32'd0);
        check_eq("drain_done_addr", addr, 32'h100);
        check_eq("drain_done_req", 32'(req), 32'd1);

        // Redirect coincident with ack: the word is dropped.
        rdata    = mem_word(32'h100);
        redir_v  = 1'b1;
        redir_pc = 32'h40;
        tick();
        redir_v = 1'b0;
        check_eq("redir_ack_valid", 32'(valid), 32'd0);
        check_eq("redir_ack_addr", addr, 32'h40);
        rdata = mem_word(32'h40);
        tick();
        check_eq("tgt_valid", 32'(valid), 32'd1);
        check_eq("tgt_pc", pc, 32'h40);
        check_eq("tgt_pc4", pc4, 32'h44);
        check_eq("tgt_instr", instr, mem_word(32'h40));

        // Asynchronous reset in the middle of a request.
        ack = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_req", 32'(req), 32'd0);
        check_eq("async_rst_valid", 32'(valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("rerst_req", 32'(req), 32'd1);
        check_eq("rerst_addr", addr, 32'h0);

        // Second instance starts at the top of the address space.
        check_eq("wrap_addr0", addr2, 32'hFFFF_FFFC);
        check_eq("wrap_req", 32'(req2), 32'd1);
        ack2   = 1'b1;
        rdata2 = 32'h1234_5678;
        tick();
        ack2 = 1'b0;
        check_eq("wrap_pc", pc2, 32'hFFFF_FFFC);
        check_eq("wrap_pc4", pc4_2, 32'h0);
        check_eq("wrap_addr1", addr2, 32'h0);
        check_eq("wrap_opcode", 32'(opcode2), 32'h4);
        check_eq("idle_valid", 32'(valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter ADDR_W, default 32: PC and memory address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  instruction memory request, held until imem_ack.
REQ-006 imem_addr  output  ADDR_W  word-aligned fetch address, stable while imem_req=1.
REQ-007 imem_ack  input  1  one-cycle response strobe; imem_rdata valid this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 redirect_valid  input  1  branch/jump redirect request.
REQ-010 redirect_pc  input  ADDR_W  redirect target; bits [1:0] ignored.
REQ-011 id_valid  output  1  IF/ID register holds a valid instruction.
REQ-012 id_ready  input  1  decode stage accepts; transfer when id_valid & id_ready.
REQ-013 id_instr  output  32  instruction word to decode.
REQ-014 id_opcode  output  6  id_instr[31:26], feeds the control unit OpCode input.
REQ-015 id_pc  output  ADDR_W  address of id_instr.
REQ-016 id_pc_plus4  output  ADDR_W  id_pc + 4, modulo 2^ADDR_W.

Function
REQ-017 FSM states SHALL be FETCH (imem_req=1), STALL (imem_req=0), DRAIN (imem_req=1, response discarded).
REQ-018 imem_addr SHALL equal the PC register in FETCH and the abandoned address in DRAIN.
REQ-019 Output slot free SHALL mean id_valid=0 or id_ready=1 in the same cycle.
REQ-020 FETCH + imem_ack + slot free + skid empty: IF/ID loads {rdata, pc}; PC += 4; stay FETCH.
REQ-021 FETCH + imem_ack + slot not free: word and PC go to one-entry skid buffer; PC += 4; go STALL.
REQ-022 STALL + slot free: IF/ID loads from skid, skid empties, go FETCH next cycle.
REQ-023 Skid contents SHALL have priority over new memory data for the IF/ID register.
REQ-024 id_valid SHALL clear when the entry is accepted and no replacement is loaded that cycle.
REQ-025 PC increment SHALL wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000; id_pc_plus4 wraps likewise.
REQ-026 redirect_valid SHALL: PC <= {redirect_pc[ADDR_W-1:2],2'b00}; clear id_valid and skid, same edge.
REQ-027 Redirect in FETCH without ack SHALL go DRAIN, holding imem_req and the old address.
REQ-028 Redirect coincident with imem_ack SHALL discard the data and go FETCH at the redirect target.
REQ-029 DRAIN + imem_ack: data discarded, PC unchanged, go FETCH.
REQ-030 Redirect during DRAIN SHALL update PC and remain in DRAIN.
REQ-031 Redirect in STALL SHALL go FETCH at the redirect target.
REQ-032 Redirect SHALL override a same-cycle id_ready transfer; the accepted entry is still consumed.
REQ-033 imem_ack outside FETCH/DRAIN SHALL be ignored.

Reset
REQ-034 While rst_n=0: state FETCH, PC=RESET_PC, skid empty, imem_req=0, id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=0.
REQ-035 imem_req SHALL first assert in the first cycle after rst_n deasserts.
REQ-036 Reset mid-request SHALL abandon the outstanding request without drain.

Structure
REQ-037 Shared package SHALL hold the FSM state enum, OPCODE_MSB/LSB (31/26), and the INSTR_W=32 constant.
REQ-038 Skid buffer SHALL be sub-module if_skid_buffer (one entry, data+pc, full flag).
REQ-039 id_opcode SHALL be a slice of the IF/ID register, with no extra logic.

Verification
REQ-040 Reset release, ack every cycle, id_ready=1 -> id_pc 0,4,8,...; id_opcode = rdata[31:26].
REQ-041 id_ready=0 for 3 cycles, ack at pc=8 -> skid holds 8, imem_req=0; on id_ready=1, id_pc 4 then 8; FETCH resumes at 12.
REQ-042 Redirect to 32'h0000_0103 with request outstanding at 16 -> DRAIN; ack at 16 discarded; next imem_addr=32'h0000_0100.
REQ-043 Redirect to 32'h40 coincident with ack -> no id_valid for that word; next imem_addr=32'h40.
REQ-044 RESET_PC=32'hFFFF_FFFC -> first id_pc_plus4=0; second imem_addr=0.
REQ-045 rst_n low mid-WAIT -> imem_req=0 and id_valid=0 immediately; refetch from RESET_PC.
